// File: rtl/pipelined_cla_adder_pkg.sv
// cla_pkg: operation modes and carry-in helpers shared by the pipelined CLA adder
package cla_pkg;
    localparam int GROUP_BITS = 4;
    typedef enum logic [1:0] {ADD = 2'd0, ADC = 2'd1, SUB = 2'd2, SBC = 2'd3} cla_mode_e;
    function automatic logic is_sub(cla_mode_e mode);
        return (mode == SUB) || (mode == SBC);
    endfunction
    function automatic logic cin_eff(cla_mode_e mode, logic cin);
        return (mode == ADD) ? 1'b0 : (mode == SUB) ? 1'b1 : cin;
    endfunction
endpackage

// File: rtl/pipelined_cla_adder_slice.sv
// cla_slice: combinational two-level carry-lookahead over 4-bit groups
module cla_slice import cla_pkg::*; #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic            i_cin,
    output logic [BITS-1:0] o_sum,
    output logic            o_cout,
    output logic            o_c_msb
);
    localparam int NG = BITS / GROUP_BITS;
    logic [BITS-1:0] w_p, w_g;
    logic [NG-1:0]   w_gp, w_gg;
    logic [NG:0]     w_gc;
    logic [BITS:0]   w_c;
    logic            w_t;
    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;
    always_comb begin
        w_gp = '0;
        w_gg = '0;
        w_gc = '0;
        w_c  = '0;
        w_t  = 1'b0;
        for (int j = 0; j < NG; j++) begin
            w_gp[j] = &w_p[j*4 +: 4];
            w_gg[j] = w_g[j*4+3] | (w_p[j*4+3] & w_g[j*4+2]) | (&w_p[j*4+2 +: 2] & w_g[j*4+1])
                    | (&w_p[j*4+1 +: 3] & w_g[j*4]);
        end
        w_gc[0] = i_cin;
        for (int j = 0; j < NG; j++) begin
            w_t = i_cin;
            for (int i = 0; i <= j; i++) w_t = w_t & w_gp[i];
            w_gc[j+1] = w_t;
            for (int i = 0; i <= j; i++) begin
                w_t = w_gg[i];
                for (int m = i + 1; m <= j; m++) w_t = w_t & w_gp[m];
                w_gc[j+1] = w_gc[j+1] | w_t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            w_c[j*4]   = w_gc[j];
            w_c[j*4+1] = w_g[j*4] | (w_p[j*4] & w_gc[j]);
            w_c[j*4+2] = w_g[j*4+1] | (w_p[j*4+1] & w_g[j*4]) | (&w_p[j*4 +: 2] & w_gc[j]);
            w_c[j*4+3] = w_g[j*4+2] | (w_p[j*4+2] & w_g[j*4+1]) | (&w_p[j*4+1 +: 2] & w_g[j*4])
                       | (&w_p[j*4 +: 3] & w_gc[j]);
        end
        w_c[BITS] = w_gc[NG];
    end
    assign o_sum   = w_p ^ w_c[BITS-1:0];
    assign o_cout  = w_c[BITS];
    assign o_c_msb = w_c[BITS-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: skewed CLA adder/subtractor, one slice per stage, valid/ready flow
module pipelined_cla_adder import cla_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int STAGE_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  cla_mode_e        in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int STAGES = WIDTH / STAGE_BITS;
    logic                  r_v [STAGES];
    logic                  r_c [STAGES];
    logic [WIDTH-1:0]      r_a [STAGES];
    logic [WIDTH-1:0]      r_b [STAGES];
    logic [WIDTH-1:0]      r_s [STAGES];
    logic [STAGES:0]       w_load;
    logic [STAGE_BITS-1:0] w_ss [STAGES];
    logic [WIDTH-1:0]      w_sm [STAGES];
    logic                  w_co [STAGES];
    logic                  w_cm [STAGES];
    if ((WIDTH % STAGE_BITS != 0) || !(STAGE_BITS == 4 || STAGE_BITS == 8 || STAGE_BITS == 12 || STAGE_BITS == 16)) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGE_BITS in {4,8,12,16}");
    end
    assign w_load[STAGES] = out_ready;
    assign in_ready  = w_load[0];
    assign out_valid = r_v[STAGES-1];
    assign out_sum   = w_sm[STAGES-1];
    assign out_cout  = w_co[STAGES-1];
    assign out_ovf   = w_co[STAGES-1] ^ w_cm[STAGES-1];
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(.BITS(STAGE_BITS)) u_slice (
            .i_a    (r_a[k][k*STAGE_BITS +: STAGE_BITS]),
            .i_b    (r_b[k][k*STAGE_BITS +: STAGE_BITS]),
            .i_cin  (r_c[k]),
            .o_sum  (w_ss[k]),
            .o_cout (w_co[k]),
            .o_c_msb(w_cm[k])
        );
        // slices above k are still zero here, so OR inserts slice k
        assign w_sm[k]   = r_s[k] | (WIDTH'(w_ss[k]) << (k * STAGE_BITS));
        assign w_load[k] = !r_v[k] || w_load[k+1];
        if (k == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v[k] <= 1'b0;
                    r_c[k] <= 1'b0;
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                    r_s[k] <= '0;
                end else if (w_load[k]) begin
                    r_v[k] <= in_valid;
                    r_c[k] <= cin_eff(in_mode, in_cin);
                    r_a[k] <= in_a;
                    r_b[k] <= is_sub(in_mode) ? ~in_b : in_b;
                    r_s[k] <= '0;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v[k] <= 1'b0;
                    r_c[k] <= 1'b0;
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                    r_s[k] <= '0;
                end else if (w_load[k]) begin
                    r_v[k] <= r_v[k-1];
                    r_c[k] <= w_co[k-1];
                    r_a[k] <= r_a[k-1];
                    r_b[k] <= r_b[k-1];
                    r_s[k] <= w_sm[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench for the 32/16, 64/8 and 16/16 adder configurations
module tb_pipelined_cla_adder;
    import cla_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_cin = 1'b0;
    logic        out_ready0 = 1'b1;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    cla_mode_e   in_mode = ADD;
    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [31:0] out_sum0;
    logic [63:0] out_sum1;
    logic [15:0] out_sum2;
    logic        out_cout0, out_cout1, out_cout2;
    logic        out_ovf0, out_ovf1, out_ovf2;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        dir_valid = 1'b0;
    logic [65:0] dir_exp = '0;
    logic [65:0] q0[$], q1[$], q2[$];
    int          run0 = 0;
    int          max_run0 = 0;
    logic        busy;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(32), .STAGE_BITS(16)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a[31:0]),
        .in_b(in_b[31:0]), .in_cin(in_cin), .in_mode(in_mode), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_sum(out_sum0), .out_cout(out_cout0), .out_ovf(out_ovf0)
    );
    pipelined_cla_adder #(.WIDTH(64), .STAGE_BITS(8)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a),
        .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode), .out_valid(out_valid1),
        .out_ready(1'b1), .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
    );
    pipelined_cla_adder #(.WIDTH(16), .STAGE_BITS(16)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a[15:0]),
        .in_b(in_b[15:0]), .in_cin(in_cin), .in_mode(in_mode), .out_valid(out_valid2),
        .out_ready(1'b1), .out_sum(out_sum2), .out_cout(out_cout2), .out_ovf(out_ovf2)
    );

    task automatic check(string tag, logic [65:0] got, logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns {ovf, cout, sum} for a w-bit adder
    function automatic logic [65:0] model(logic [63:0] a, logic [63:0] b, logic cin, cla_mode_e m, int w);
        logic [63:0] mask, am, be;
        logic [64:0] s;
        logic        c;
        mask = (64'd1 << w) - 64'd1;
        am   = a & mask;
        be   = ((m == SUB || m == SBC) ? ~b : b) & mask;
        c    = (m == ADD) ? 1'b0 : (m == SUB) ? 1'b1 : cin;
        s    = {1'b0, am} + {1'b0, be} + 65'(c);
        return {(am[w-1] == be[w-1]) && (s[w-1] != am[w-1]), s[w], s[63:0] & mask};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
            run0 = 0;
        end else begin
            if (in_valid && in_ready0) q0.push_back(dir_valid ? dir_exp : model(in_a, in_b, in_cin, in_mode, 32));
            if (in_valid && in_ready1) q1.push_back(model(in_a, in_b, in_cin, in_mode, 64));
            if (in_valid && in_ready2) q2.push_back(model(in_a, in_b, in_cin, in_mode, 16));
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) check("d0_spurious", 66'(q0.size()), 66'd1);
                else check("d0_result", {out_ovf0, out_cout0, 32'h0, out_sum0}, q0.pop_front());
            end
            if (out_valid1) begin
                if (q1.size() == 0) check("d1_spurious", 66'(q1.size()), 66'd1);
                else check("d1_result", {out_ovf1, out_cout1, out_sum1}, q1.pop_front());
            end
            if (out_valid2) begin
                if (q2.size() == 0) check("d2_spurious", 66'(q2.size()), 66'd1);
                else check("d2_result", {out_ovf2, out_cout2, 48'h0, out_sum2}, q2.pop_front());
            end
            run0 = out_valid0 ? run0 + 1 : 0;
            if (run0 > max_run0) max_run0 = run0;
        end
    end

    task automatic send(logic [63:0] a, logic [63:0] b, logic cin, cla_mode_e m, logic dv, logic [65:0] de);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_mode = m;
        in_valid = 1'b1;
        dir_valid = dv;
        dir_exp = de;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", 66'(in_ready0), 66'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        dir_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             cla_mode_e'($urandom_range(0, 3)), 1'b0, '0);
    endtask

    initial begin
        int          acc;
        logic        got;
        logic [31:0] snap;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 66'(out_valid0), 66'd0);
        check("rst_sum", 66'(out_sum0), 66'd0);
        check("rst_cout", 66'(out_cout0), 66'd0);
        check("rst_ovf", 66'(out_ovf0), 66'd0);
        check("rst_ready", 66'(in_ready0), 66'd1);
        check("rst_valid_w64", 66'(out_valid1), 66'd0);
        check("rst_valid_w16", 66'(out_valid2), 66'd0);
        @(posedge clk);
        #1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, ADD, 1'b1, {2'b01, 64'h0});
        in_valid = 1'b0;
        dir_valid = 1'b0;
        @(negedge clk);
        check("t1_lat1", 66'(out_valid0), 66'd0);
        @(negedge clk);
        check("t1_lat2", 66'(out_valid0), 66'd1);
        check("t1_sum", 66'(out_sum0), 66'd0);
        @(posedge clk);
        #1;
        send(64'h0000_FFFF, 64'h1, 1'b0, ADD, 1'b1, {2'b00, 64'h0001_0000});
        send(64'h8000_0000_8000_0000, 64'h1, 1'b0, SUB, 1'b1, {2'b11, 64'h7FFF_FFFF});
        send(64'd5, 64'd3, 1'b0, SBC, 1'b1, {2'b01, 64'h1});
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, ADC, 1'b1, {2'b01, 64'h0});
        idle(12);
        max_run0 = 0;
        for (int i = 0; i < 8; i++) send_rand();
        idle(12);
        check("t4_consecutive", 66'(max_run0), 66'd8);
        out_ready0 = 1'b0;
        acc = 0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_mode = ADD;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = in_ready0;
            if (got) acc++;
            @(posedge clk);
            #1;
            if (got) begin
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
            end
        end
        check("t5_accepts", 66'(acc), 66'd2);
        @(negedge clk);
        check("t5_full", 66'(in_ready0), 66'd0);
        check("t5_valid", 66'(out_valid0), 66'd1);
        snap = out_sum0;
        @(negedge clk);
        @(negedge clk);
        check("t5_hold", 66'(out_sum0), 66'(snap));
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        in_valid = 1'b0;
        #1;
        check("t5_ready_comb", 66'(in_ready0), 66'd1);
        idle(5);
        check("t5_drained", 66'(q0.size()), 66'd0);
        out_ready0 = 1'b0;
        send_rand();
        send_rand();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 66'(out_valid0), 66'd0);
        check("t6_valid_w64", 66'(out_valid1), 66'd0);
        check("t6_ready", 66'(in_ready0), 66'd1);
        check("t6_sum", 66'(out_sum0), 66'd0);
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        idle(12);
        busy = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) send_rand();
                busy = 1'b0;
            end
            begin
                while (busy) begin
                    @(posedge clk);
                    #1;
                    out_ready0 = 1'($urandom_range(0, 1));
                end
                out_ready0 = 1'b1;
            end
        join
        in_valid = 1'b0;
        for (int i = 0; i < 100 && (q0.size() + q1.size() + q2.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("final_drain", 66'(q0.size() + q1.size() + q2.size()), 66'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
